// File: rtl/add_mul_pkg.sv
// Shared widths and state encoding for the add/mul result accumulator.
// Optional saturation is selected with the ADD_MUL_ACC_SAT_EN macro.
package add_mul_pkg;

    localparam int MUL_W = 8;
    localparam int ADD_W = 4;

    typedef enum logic {
        ACC_ACCUM = 1'b0,
        ACC_HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/add_mul_acc_lane.sv
// One accumulator lane: zero-extend add, sticky carry-out flag, clear/enable.
// With ADD_MUL_ACC_SAT_EN defined the lane clamps at all-ones instead of wrapping.
module add_mul_acc_lane
    import add_mul_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int IN_W  = MUL_W
) (
    input  logic             i_clk_sys,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [IN_W-1:0]  i_data,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_ovf
);

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_next;

    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(i_data);

`ifdef ADD_MUL_ACC_SAT_EN
    // Once clamped, any further non-zero add carries again and keeps the clamp.
    assign w_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge i_clk_sys) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_sum[ACC_W];
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/add_mul_result_accumulator.sv
// Frame accumulator for product/sum pairs with a valid/ready result port.
// Saturating lanes are built when ADD_MUL_ACC_SAT_EN is defined; default wraps.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ACC_ACCUM | accepting beats, in_ready=1, counting towards BEATS
// ACC_HOLD  | frame totals presented, out_valid=1, upstream stalled
module add_mul_result_accumulator
    import add_mul_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int ACC_W = 16
) (
    input  logic             i_clk_sys,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [MUL_W-1:0] i_in_mul,
    input  logic [ADD_W-1:0] i_in_add,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_mac,
    output logic [ACC_W-1:0] o_out_sum,
    output logic             o_out_ovf
);

    localparam int                CNT_W    = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEATS - 1);

    acc_state_e       r_state;
    acc_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_clr;
    logic             w_mac_ovf;
    logic             w_sum_ovf;

    assign w_accept = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state <= ACC_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs decode state only; out_ready never reaches in_ready.
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ACC_ACCUM: begin
                o_in_ready = 1'b1;
                if (i_in_valid && (r_cnt == CNT_LAST)) begin
                    w_state_nxt = ACC_HOLD;
                end
            end
            ACC_HOLD: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = ACC_ACCUM;
                    w_clr       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ACC_ACCUM;
            end
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst || w_clr) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    add_mul_acc_lane #(
        .ACC_W (ACC_W),
        .IN_W  (MUL_W)
    ) u_lane_mac (
        .i_clk_sys (i_clk_sys),
        .i_rst     (i_rst),
        .i_clr     (w_clr),
        .i_en      (w_accept),
        .i_data    (i_in_mul),
        .o_acc     (o_out_mac),
        .o_ovf     (w_mac_ovf)
    );

    add_mul_acc_lane #(
        .ACC_W (ACC_W),
        .IN_W  (ADD_W)
    ) u_lane_sum (
        .i_clk_sys (i_clk_sys),
        .i_rst     (i_rst),
        .i_clr     (w_clr),
        .i_en      (w_accept),
        .i_data    (i_in_add),
        .o_acc     (o_out_sum),
        .o_ovf     (w_sum_ovf)
    );

    assign o_out_ovf = w_mac_ovf | w_sum_ovf;

endmodule
